// File: rtl/ccd_frame_streamer_pkg.sv
// ccd_pkg: shared types and constants for the CCD line streamer.
//   state_t          - streamer FSM states
//   N_PIXELS_DEFAULT - pixels per CCD line
//   SYNC0/1_DEFAULT  - packet sync bytes
//   RAM_RD_LAT       - pixel RAM read latency in clk (WAIT state is sized for 1)
//   IDX_W            - width of the pixel index counter
package ccd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    FETCH,
    WAIT,
    SEND,
    TAIL,
    FIN
  } state_t;

  localparam int unsigned N_PIXELS_DEFAULT = 5474;
  localparam logic [7:0]  SYNC0_DEFAULT    = 8'hA5;
  localparam logic [7:0]  SYNC1_DEFAULT    = 8'h5A;
  localparam int unsigned RAM_RD_LAT       = 1;
  localparam int unsigned IDX_W            = 13;

endpackage

// File: rtl/ccd_frame_streamer.sv
// ccd_frame_streamer: reads one captured CCD line out of the pixel RAM and
// frames it as SYNC0, SYNC1, len_hi, len_lo, pixels[, checksum] toward the
// host byte transmitter over a valid/ready handshake.
// Build option: define CCD_CHECKSUM_EN to append the mod-256 pixel sum byte.
// Ports:
//   clk, rst         - clock, asynchronous active-high reset
//   start            - one-cycle frame request, honoured only when idle
//   busy, done       - frame in progress / one-cycle completion pulse
//   rdaddress, rden  - RAM read port (data returns 1 clk after rden)
//   rddata           - RAM read data
//   tx_data/valid    - packet byte toward the transmitter
//   tx_ready         - transmitter accepts when tx_valid is also high
module ccd_frame_streamer
  import ccd_pkg::*;
#(
  parameter int unsigned       N_PIXELS  = N_PIXELS_DEFAULT,
  parameter int unsigned       ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [7:0]        SYNC0     = SYNC0_DEFAULT,
  parameter logic [7:0]        SYNC1     = SYNC1_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rdaddress,
  output logic              rden,
  input  logic [7:0]        rddata,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  localparam logic [15:0]      LEN      = 16'(N_PIXELS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PIXELS - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, idx_nxt_c;
  logic [1:0]       hdr_q, hdr_d;
  logic             busy_d, done_d, rden_d, tx_valid_d;
  logic [ADDR_W-1:0] rdaddress_d;
  logic [7:0]       tx_data_d;
  logic             accept_c;
`ifdef CCD_CHECKSUM_EN
  logic [7:0]       csum_q, csum_d;
`endif

  // Header byte selected by its position in the 4-byte header.
  function automatic logic [7:0] hdr_byte(input logic [1:0] pos);
    case (pos)
      2'd0:    hdr_byte = SYNC0;
      2'd1:    hdr_byte = SYNC1;
      2'd2:    hdr_byte = LEN[15:8];
      default: hdr_byte = LEN[7:0];
    endcase
  endfunction

  assign accept_c  = tx_valid & tx_ready;
  assign idx_nxt_c = idx_q + IDX_W'(1);

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      hdr_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rdaddress <= BASE_ADDR;
      rden      <= 1'b0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
`ifdef CCD_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      hdr_q     <= hdr_d;
      busy      <= busy_d;
      done      <= done_d;
      rdaddress <= rdaddress_d;
      rden      <= rden_d;
      tx_data   <= tx_data_d;
      tx_valid  <= tx_valid_d;
`ifdef CCD_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  // Next state and next output values; outputs change one clk after the decision.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    hdr_d       = hdr_q;
    busy_d      = busy;
    done_d      = 1'b0;
    rdaddress_d = rdaddress;
    rden_d      = 1'b0;
    tx_data_d   = tx_data;
    tx_valid_d  = tx_valid;
`ifdef CCD_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = HDR;
          idx_d      = '0;
          hdr_d      = '0;
          busy_d     = 1'b1;
          tx_valid_d = 1'b1;
          tx_data_d  = SYNC0;
`ifdef CCD_CHECKSUM_EN
          csum_d     = '0;
`endif
        end
      end
      HDR: begin
        if (accept_c) begin
          if (hdr_q == 2'd3) begin
            state_d     = FETCH;
            tx_valid_d  = 1'b0;
            rden_d      = 1'b1;
            rdaddress_d = BASE_ADDR + ADDR_W'(idx_q);
          end else begin
            hdr_d     = hdr_q + 2'd1;
            tx_data_d = hdr_byte(hdr_q + 2'd1);
          end
        end
      end
      FETCH: state_d = WAIT;
      // RAM data is valid this cycle; present it as the next byte.
      WAIT: begin
        state_d    = SEND;
        tx_data_d  = rddata;
        tx_valid_d = 1'b1;
`ifdef CCD_CHECKSUM_EN
        csum_d     = csum_q + rddata;
`endif
      end
      SEND: begin
        if (accept_c) begin
          if (idx_q == LAST_IDX) begin
`ifdef CCD_CHECKSUM_EN
            state_d   = TAIL;
            tx_data_d = csum_q;
`else
            state_d    = FIN;
            tx_valid_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
`endif
          end else begin
            state_d     = FETCH;
            idx_d       = idx_nxt_c;
            tx_valid_d  = 1'b0;
            rden_d      = 1'b1;
            rdaddress_d = BASE_ADDR + ADDR_W'(idx_nxt_c);
          end
        end
      end
      TAIL: begin
`ifdef CCD_CHECKSUM_EN
        if (accept_c) begin
          state_d    = FIN;
          tx_valid_d = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
        end
`else
        state_d = IDLE;
`endif
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule
